// File: rtl/full_st1_error_buffer.sv
// full_st1_error_buffer
// Phase-indexed store for the stage-1 error stream. Accepted error words are
// written by (error_phase, error_sub_address); on an error update request one
// phase worth of words is played back to the tap-update datapath over a
// valid/ready handshake with first/last/index markers.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   error_valid/value       write strobe and error word
//   error_phase             write phase slot
//   error_sub_address       word index within phase (legal: < SUB_DEPTH)
//   error_update_first/mode playback request (both high)
//   error_phase_read        phase slot to play back, sampled with request
//   tap_error_rdy           downstream accepts current beat
//   tap_error*              playback beat data/valid/first/last/index
//   read_busy               playback in progress
//   phase_filled            per-phase complete flag
//   err_underrun/overwrite/address  sticky error flags
module full_st1_error_buffer #(
    parameter int DATA_W    = 32,
    parameter int SUB_DEPTH = 6,
    parameter int PHASES    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              error_valid,
    input  logic [DATA_W-1:0] error_value,
    input  logic [1:0]        error_phase,
    input  logic [31:0]       error_sub_address,
    input  logic              error_update_first,
    input  logic              error_update_mode,
    input  logic [1:0]        error_phase_read,
    input  logic              tap_error_rdy,
    output logic [DATA_W-1:0] tap_error,
    output logic              tap_error_vld,
    output logic              tap_error_first,
    output logic              tap_error_last,
    output logic [2:0]        tap_error_index,
    output logic              read_busy,
    output logic [PHASES-1:0] phase_filled,
    output logic              err_underrun,
    output logic              err_overwrite,
    output logic              err_address
);
    localparam int DEPTH = PHASES * SUB_DEPTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = 3;

    typedef enum logic {IDLE, READ} state_t;

    logic [DATA_W-1:0] store [DEPTH];

    state_t            state_q, state_d;
    logic [1:0]        rd_phase_q, rd_phase_d;
    logic [PHASES-1:0] filled_q, filled_d;
    logic [DATA_W-1:0] tap_q, tap_d;
    logic              vld_q, vld_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              underrun_q, underrun_d;
    logic              overwrite_q, overwrite_d;
    logic              address_q, address_d;

    logic              wr_ok;
    logic              req;
    logic [IW-1:0]     idx_nxt;
    logic [PHASES-1:0] fill_set, fill_clr;

    function automatic logic [AW-1:0] addr(input logic [1:0] ph, input logic [IW-1:0] sub);
        return AW'(ph) * AW'(SUB_DEPTH) + AW'(sub);
    endfunction

    always_comb begin
        state_d     = state_q;
        rd_phase_d  = rd_phase_q;
        tap_d       = tap_q;
        vld_d       = vld_q;
        first_d     = first_q;
        last_d      = last_q;
        idx_d       = idx_q;
        underrun_d  = underrun_q;
        overwrite_d = overwrite_q;
        address_d   = address_q;
        fill_set    = '0;
        fill_clr    = '0;

        wr_ok   = error_valid && (error_sub_address < 32'(SUB_DEPTH));
        req     = error_update_first && error_update_mode;
        idx_nxt = idx_q + 1'b1;

        if (error_valid && !wr_ok)
            address_d = 1'b1;
        if (wr_ok && error_sub_address == 32'(SUB_DEPTH - 1))
            fill_set[error_phase] = 1'b1;

        unique case (state_q)
            IDLE: begin
                // Filled check uses the registered flag, so a request in the
                // same cycle as the completing write underruns.
                if (req) begin
                    if (filled_q[error_phase_read]) begin
                        state_d    = READ;
                        rd_phase_d = error_phase_read;
                        tap_d      = store[addr(error_phase_read, '0)];
                        vld_d      = 1'b1;
                        first_d    = 1'b1;
                        last_d     = (SUB_DEPTH == 1);
                        idx_d      = '0;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (wr_ok && error_phase == rd_phase_q)
                    overwrite_d = 1'b1;
                if (vld_q && tap_error_rdy) begin
                    if (last_q) begin
                        state_d  = IDLE;
                        vld_d    = 1'b0;
                        first_d  = 1'b0;
                        last_d   = 1'b0;
                        fill_clr[rd_phase_q] = 1'b1;
                    end else begin
                        idx_d   = idx_nxt;
                        tap_d   = store[addr(rd_phase_q, idx_nxt)];
                        first_d = 1'b0;
                        last_d  = (idx_nxt == IW'(SUB_DEPTH - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A set and clear on the same phase resolve to set.
        filled_d = (filled_q & ~fill_clr) | fill_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_phase_q  <= '0;
            filled_q    <= '0;
            tap_q       <= '0;
            vld_q       <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            idx_q       <= '0;
            underrun_q  <= 1'b0;
            overwrite_q <= 1'b0;
            address_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_phase_q  <= rd_phase_d;
            filled_q    <= filled_d;
            tap_q       <= tap_d;
            vld_q       <= vld_d;
            first_q     <= first_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            underrun_q  <= underrun_d;
            overwrite_q <= overwrite_d;
            address_q   <= address_d;
        end
    end

    // Store is not reset; writes are accepted in every state.
    always_ff @(posedge clk) begin
        if (wr_ok)
            store[addr(error_phase, error_sub_address[IW-1:0])] <= error_value;
    end

    assign tap_error       = tap_q;
    assign tap_error_vld   = vld_q;
    assign tap_error_first = first_q;
    assign tap_error_last  = last_q;
    assign tap_error_index = idx_q;
    assign read_busy       = (state_q == READ);
    assign phase_filled    = filled_q;
    assign err_underrun    = underrun_q;
    assign err_overwrite   = overwrite_q;
    assign err_address     = address_q;
endmodule
